harq_combine_ctrl: RTL and testbench

//  Sequences one HARQ soft-combine job per code block: pulls descrambled bytes, issues HARQ buffer reads,

---
 rtl/harq_combine_ctrl_if.sv | 27 ++
 rtl/harq_combine_ctrl.sv | 136 +++++++++++++
 tb/tb_harq_combine_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/harq_combine_ctrl_if.sv
// rtl/harq_combine_ctrl_if.sv - descr_buf handshake, HARQ memory ports and combine strobe of harq_combine_ctrl
interface harq_combine_ctrl_if #(
  parameter int AW = 12
);
  logic          i_descr_vld;
  logic          i_hold;
  logic          o_descr_rdy;
  logic          o_descr_buf_data_strb;
  logic          o_harq_rd_en;
  logic [AW-1:0] o_harq_rd_addr;
  logic          o_rcombine_zero;
  logic          i_combine_data_strb;
  logic          o_harq_wr_en;
  logic [AW-1:0] o_harq_wr_addr;

  modport master (
    input  i_descr_vld, i_hold, i_combine_data_strb,
    output o_descr_rdy, o_descr_buf_data_strb, o_harq_rd_en, o_harq_rd_addr,
           o_rcombine_zero, o_harq_wr_en, o_harq_wr_addr
  );

  modport slave (
    output i_descr_vld, i_hold, i_combine_data_strb,
    input  o_descr_rdy, o_descr_buf_data_strb, o_harq_rd_en, o_harq_rd_addr,
           o_rcombine_zero, o_harq_wr_en, o_harq_wr_addr
  );
endinterface

// File: rtl/harq_combine_ctrl.sv
// rtl/harq_combine_ctrl.sv - HARQ soft-combine job sequencer; HARQ_CTRL_PERF_CNT_EN adds the stall counter
module harq_combine_ctrl #(
  parameter int AW        = 12,
  parameter int LW        = 13,
  parameter int MEM_DEPTH = 4096
) (
  input  logic                 i_harq_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [AW-1:0]        i_base_addr,
  input  logic [LW-1:0]        i_len,
  input  logic                 i_first_tx,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err_start,
  output logic                 o_err_wr,
  output logic [15:0]          o_stall_cnt,
  harq_combine_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] len_q;
  logic          first_tx_q;
  logic [LW-1:0] acc_cnt_q, acc_cnt_d;
  logic [LW-1:0] wr_cnt_q, wr_cnt_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] rd_ptr_inc;
  logic [1:0]    pipe_vld_q;
  logic [AW-1:0] pipe_addr0_q, pipe_addr1_q;
  logic          rcz_q;

  logic start_ok;
  logic rdy;
  logic accept;
  logic wr_fire;

  assign start_ok = i_start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign rdy      = (state_q == S_RUN) && !bus.i_hold && (acc_cnt_q < len_q);
  assign accept   = bus.i_descr_vld && rdy;
  // Stage 1 of the address pipe lines up with the combine strobe two cycles after accept.
  assign wr_fire  = bus.i_combine_data_strb && pipe_vld_q[1];

  assign rd_ptr_inc = (rd_ptr_q == AW'(MEM_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    acc_cnt_d = acc_cnt_q + LW'(accept);
    wr_cnt_d  = wr_cnt_q + LW'(wr_fire);
    rd_ptr_d  = accept ? rd_ptr_inc : rd_ptr_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start_ok) begin
          state_d   = (i_len == '0) ? S_DONE : S_RUN;
          acc_cnt_d = '0;
          wr_cnt_d  = '0;
          rd_ptr_d  = i_base_addr;
        end
      end
      S_RUN: begin
        if (acc_cnt_d == len_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (wr_cnt_d == len_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_harq_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      first_tx_q   <= 1'b0;
      acc_cnt_q    <= '0;
      wr_cnt_q     <= '0;
      rd_ptr_q     <= '0;
      pipe_vld_q   <= '0;
      pipe_addr0_q <= '0;
      pipe_addr1_q <= '0;
      rcz_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_cnt_q    <= acc_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      pipe_vld_q   <= {pipe_vld_q[0], accept};
      pipe_addr0_q <= rd_ptr_q;
      pipe_addr1_q <= pipe_addr0_q;
      rcz_q        <= first_tx_q && accept;
      if (start_ok) begin
        len_q      <= i_len;
        first_tx_q <= i_first_tx;
      end
    end
  end

  assign o_busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign o_done      = (state_q == S_DONE);
  assign o_err_start = i_start && o_busy;
  assign o_err_wr    = bus.i_combine_data_strb && !pipe_vld_q[1];

  assign bus.o_descr_rdy           = rdy;
  assign bus.o_descr_buf_data_strb = accept;
  assign bus.o_harq_rd_en          = accept && !first_tx_q;
  assign bus.o_harq_rd_addr        = accept ? rd_ptr_q : '0;
  assign bus.o_rcombine_zero       = rcz_q;
  assign bus.o_harq_wr_en          = wr_fire;
  assign bus.o_harq_wr_addr        = wr_fire ? pipe_addr1_q : '0;

`ifdef HARQ_CTRL_PERF_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge i_harq_clk or posedge i_rst) begin
    if (i_rst) begin
      stall_cnt_q <= '0;
    end else if (start_ok) begin
      stall_cnt_q <= '0;
    end else if ((state_q == S_RUN) && bus.i_descr_vld && !rdy && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`else
  assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_harq_combine_ctrl.sv
// tb/tb_harq_combine_ctrl.sv - directed bench with per-cycle job model for harq_combine_ctrl
module tb_harq_combine_ctrl;
  localparam int AW = 12;
  localparam int LW = 13;
  localparam int DEPTH = 4096;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base;
  logic [LW-1:0] len;
  logic          ft;
  logic          busy, done, err_start, err_wr;
  logic [15:0]   stall;

  harq_combine_ctrl_if #(.AW(AW)) hif ();

  harq_combine_ctrl #(.AW(AW), .LW(LW), .MEM_DEPTH(DEPTH)) dut (
    .i_harq_clk  (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_base_addr (base),
    .i_len       (len),
    .i_first_tx  (ft),
    .o_busy      (busy),
    .o_done      (done),
    .o_err_start (err_start),
    .o_err_wr    (err_wr),
    .o_stall_cnt (stall),
    .bus         (hif)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // model of the job as the datapath sees it
  int m_mode = M_IDLE, m_acc = 0, m_wr = 0, m_len = 0, m_base = 0, m_ft = 0;
  int m_stall = 0, m_rcz = 0, cyc = 0;
  int wq_addr[$];
  int wq_due[$];
  logic h0 = 1'b0, h1 = 1'b0;

  int log_rd[$];
  int log_wr[$];
  int n_rden, n_rcz, n_done, n_errs, n_errw, n_strb, first_acc_cyc, done_cyc;
  bit seen_done;

  logic e_busy, e_done, e_errs, e_errw, e_rdy, e_strb, e_rden, e_wr, has, start_ok;
  int   e_ra, e_wa, e_stall;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("rst_busy", busy, 0);          chk("rst_done", done, 0);
      chk("rst_err_start", err_start, 0); chk("rst_err_wr", err_wr, 0);
      chk("rst_rdy", hif.o_descr_rdy, 0); chk("rst_strb", hif.o_descr_buf_data_strb, 0);
      chk("rst_rd_en", hif.o_harq_rd_en, 0); chk("rst_rd_addr", hif.o_harq_rd_addr, 0);
      chk("rst_rcz", hif.o_rcombine_zero, 0); chk("rst_wr_en", hif.o_harq_wr_en, 0);
      chk("rst_wr_addr", hif.o_harq_wr_addr, 0); chk("rst_stall", stall, 0);
      m_mode = M_IDLE; m_acc = 0; m_wr = 0; m_len = 0; m_base = 0; m_ft = 0;
      m_stall = 0; m_rcz = 0; h0 = 1'b0; h1 = 1'b0;
      wq_addr.delete(); wq_due.delete();
    end else begin
      e_busy = (m_mode == M_RUN) || (m_mode == M_DRAIN);
      e_done = (m_mode == M_DONE);
      e_errs = start && e_busy;
      e_rdy  = (m_mode == M_RUN) && !hif.i_hold && (m_acc < m_len);
      e_strb = hif.i_descr_vld && e_rdy;
      e_rden = e_strb && (m_ft == 0);
      e_ra   = e_strb ? (m_base + m_acc) % DEPTH : 0;
      while (wq_due.size() > 0 && wq_due[0] < cyc) begin
        void'(wq_due.pop_front()); void'(wq_addr.pop_front());
      end
      has    = (wq_due.size() > 0) && (wq_due[0] == cyc);
      e_wr   = hif.i_combine_data_strb && has;
      e_errw = hif.i_combine_data_strb && !has;
      e_wa   = e_wr ? wq_addr[0] : 0;
`ifdef HARQ_CTRL_PERF_CNT_EN
      e_stall = m_stall;
`else
      e_stall = 0;
`endif
      chk("busy", busy, e_busy);           chk("done", done, e_done);
      chk("err_start", err_start, e_errs); chk("err_wr", err_wr, e_errw);
      chk("rdy", hif.o_descr_rdy, e_rdy);  chk("strb", hif.o_descr_buf_data_strb, e_strb);
      chk("rd_en", hif.o_harq_rd_en, e_rden); chk("rd_addr", hif.o_harq_rd_addr, e_ra);
      chk("rcz", hif.o_rcombine_zero, m_rcz); chk("wr_en", hif.o_harq_wr_en, e_wr);
      chk("wr_addr", hif.o_harq_wr_addr, e_wa); chk("stall_cnt", stall, e_stall);

      if (hif.o_descr_buf_data_strb) begin
        log_rd.push_back(int'(hif.o_harq_rd_addr)); n_strb++;
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
      end
      if (hif.o_harq_wr_en) log_wr.push_back(int'(hif.o_harq_wr_addr));
      if (hif.o_harq_rd_en) n_rden++;
      if (hif.o_rcombine_zero) n_rcz++;
      if (err_start) n_errs++;
      if (err_wr) n_errw++;
      if (done) begin n_done++; done_cyc = cyc; seen_done = 1'b1; end

      start_ok = start && ((m_mode == M_IDLE) || (m_mode == M_DONE));
      if (start_ok) m_stall = 0;
      else if ((m_mode == M_RUN) && hif.i_descr_vld && !e_rdy && m_stall < 65535) m_stall++;
      m_rcz = (e_strb && m_ft != 0) ? 1 : 0;
      if (e_wr) begin void'(wq_due.pop_front()); void'(wq_addr.pop_front()); m_wr++; end
      if (e_strb) begin wq_addr.push_back(e_ra); wq_due.push_back(cyc + 2); m_acc++; end
      h1 = h0; h0 = e_strb;
      case (m_mode)
        M_IDLE, M_DONE: begin
          m_mode = M_IDLE;
          if (start_ok) begin
            m_base = int'(base); m_len = int'(len); m_ft = int'(ft);
            m_acc = 0; m_wr = 0;
            m_mode = (len == 0) ? M_DONE : M_RUN;
          end
        end
        M_RUN:   if (m_acc == m_len) m_mode = M_DRAIN;
        M_DRAIN: if (m_wr == m_len) m_mode = M_DONE;
        default: m_mode = M_IDLE;
      endcase
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
    hif.i_combine_data_strb = h1;
  endtask

  task automatic clr_logs();
    log_rd.delete(); log_wr.delete();
    n_rden = 0; n_rcz = 0; n_done = 0; n_errs = 0; n_errw = 0; n_strb = 0;
    first_acc_cyc = -1; done_cyc = -1; seen_done = 1'b0;
  endtask

  task automatic run_job(input int b, input int l, input int f, input int hs, input int hn, input int es);
    int k;
    clr_logs();
    nxt(); start = 1'b1; base = AW'(b); len = LW'(l); ft = f[0];
    nxt(); start = 1'b0; base = 12'hABC; len = 13'd7; ft = ~f[0]; hif.i_descr_vld = 1'b1;
    k = 0;
    while (!seen_done && k < 80) begin
      hif.i_hold = (k >= hs) && (k < hs + hn);
      start = (k == es);
      nxt();
      k++;
    end
    start = 1'b0; hif.i_hold = 1'b0; hif.i_descr_vld = 1'b0;
    if (!seen_done) chk("job_timeout", 0, 1);
  endtask

  task automatic chk_list(input string name, input int got[$], input int exp[$]);
    chk({name, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) chk(name, got[i], exp[i]);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base = '0; len = '0; ft = 1'b0;
    hif.i_descr_vld = 1'b0; hif.i_hold = 1'b0; hif.i_combine_data_strb = 1'b0;
    clr_logs();
    repeat (3) nxt();
    rst = 1'b0;
    repeat (2) nxt();

    // 1: plain job, latency of done from first accept
    run_job(12'h010, 4, 0, 100, 0, -1);
    chk_list("t1_rd", log_rd, '{12'h010, 12'h011, 12'h012, 12'h013});
    chk_list("t1_wr", log_wr, '{12'h010, 12'h011, 12'h012, 12'h013});
    chk("t1_done_lat", done_cyc - first_acc_cyc, 6);
    chk("t1_rd_en", n_rden, 4);

    // 2: address wrap
    run_job(12'hFFE, 4, 0, 100, 0, -1);
    chk_list("t2_wr", log_wr, '{12'hFFE, 12'hFFF, 12'h000, 12'h001});
    chk("t2_done_once", n_done, 1);

    // 3: first transmission
    run_job(12'h300, 3, 1, 100, 0, -1);
    chk("t3_rd_en", n_rden, 0);
    chk("t3_rcz", n_rcz, 3);
    chk("t3_writes", log_wr.size(), 3);

    // 4: two-cycle hold
    run_job(12'h040, 5, 0, 2, 2, -1);
    chk_list("t4_wr", log_wr, '{12'h040, 12'h041, 12'h042, 12'h043, 12'h044});
`ifdef HARQ_CTRL_PERF_CNT_EN
    chk("t4_stall", stall, 2);
`else
    chk("t4_stall", stall, 0);
`endif

    // 5: start while busy, then zero-length job
    run_job(12'h100, 4, 0, 100, 0, 1);
    chk("t5_err_start", n_errs, 1);
    chk_list("t5_wr", log_wr, '{12'h100, 12'h101, 12'h102, 12'h103});
    clr_logs();
    nxt(); start = 1'b1; len = '0; base = 12'h055;
    nxt(); start = 1'b0;
    @(negedge clk); #1;
    chk("t5_len0_done", done, 1);
    repeat (3) nxt();
    chk("t5_len0_strobes", n_strb, 0);

    // stray combine strobe with nothing pending
    clr_logs();
    nxt(); hif.i_combine_data_strb = 1'b1;
    nxt();
    chk("stray_err_wr", n_errw, 1);

    // 6: reset in the middle of a job
    clr_logs();
    nxt(); start = 1'b1; base = 12'h020; len = 13'd6; ft = 1'b0;
    nxt(); start = 1'b0; hif.i_descr_vld = 1'b1;
    nxt();
    nxt(); rst = 1'b1; hif.i_combine_data_strb = 1'b0;
    nxt(); rst = 1'b0; hif.i_descr_vld = 1'b0;
    repeat (8) nxt();
    chk("t6_no_done", n_done, 0);
    chk("t6_accepts", n_strb, 2);
    chk("t6_writes", log_wr.size(), 0);
    run_job(12'h7FF, 1, 0, 100, 0, -1);
    chk_list("t6_wr", log_wr, '{12'h7FF});
    chk("t6_done", n_done, 1);

    repeat (2) nxt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
